uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- UART receiver for the SoC, 8N1 framing, paired with the existing transmit path that drives the host-facing serial line.
- Samples the host TX line and deserialises bytes.
- Received bytes go into a first-word-fall-through FIFO with a valid/ready read port, which the AXI-Lite UART register block consumes.
- Reports framing errors and overruns as single-cycle status pulses.

Parameters:
CLK_FREQ_HZ, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate
FIFO_DEPTH, 16, receive FIFO entries; must be a power of two and at least 2
Derived: CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE (integer division). Must be at least 4, otherwise elaboration fails.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset, asynchronous assert, active-low
i_uart_rx  input  1  serial line from host TX; asynchronous to i_clk; idles high
o_rx_data  output  8  byte at FIFO head; valid only while o_rx_valid=1
o_rx_valid  output  1  FIFO not empty
i_rx_ready  input  1  consumer accepts the head byte when o_rx_valid and i_rx_ready are both 1
o_fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of stored bytes
o_busy  output  1  high in every state except IDLE
o_frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0
o_overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full

Behaviour:
- Reset is asynchronous, active-low, fixed by the team.
- Reset values:
  - All outputs are 0 (o_rx_data=0x00).
  - FSM is in IDLE, FIFO pointers and count are 0.
  - Both synchroniser flops reset to 1.
- Input synchronisation: i_uart_rx passes through a 2-flop synchroniser. All FSM decisions use the synchronised line ("rxs").
- One bit counter counts 0..CLKS_PER_BIT-1. One 3-bit index counts data bits.
- FSM states and transitions:
  - IDLE: when rxs=0, go to START and clear the counter.
  - START: when the counter reaches CLKS_PER_BIT/2-1, sample rxs.
    - If 0: go to DATA, clear counter and index.
    - If 1: treat as a glitch, return to IDLE, no error.
  - DATA: when the counter reaches CLKS_PER_BIT-1, sample rxs into the shift register LSB first and clear the counter.
    - After index 7 has been sampled, go to STOP.
  - STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs.
    - If 1 and FIFO not full, or FIFO full with a pop in the same cycle: push the byte, go to IDLE.
    - If 1 and FIFO full with no pop: drop the byte, pulse o_overrun, go to IDLE.
    - If 0: pulse o_frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. A held-low line (break condition) never generates repeated frames.
- Sampling point: the START check lands at mid-bit, so all later samples also land at mid-bit.
- Latency: the pushed byte appears on o_rx_data/o_rx_valid in the cycle after the stop-bit sample cycle. o_fifo_level updates in that same cycle.
- FIFO:
  - First-word-fall-through: o_rx_data always shows the head entry.
  - Pop occurs when o_rx_valid=1 and i_rx_ready=1. Pop while empty is ignored.
  - Simultaneous push and pop: the count is unchanged and data order is preserved. This includes the full case, where the push is accepted because of the pop.
  - Pointers wrap modulo FIFO_DEPTH. Entry contents are not cleared on reset.
- o_frame_err and o_overrun are never asserted in the same cycle. Each is high for exactly one cycle per event.
- Reset asserted mid-frame: immediate return to reset state. The partial byte is lost and FIFO contents are lost.

Test Plan:
All scenarios use CLK_FREQ_HZ=100000000, BAUD_RATE=10000000 (CLKS_PER_BIT=10) and FIFO_DEPTH=16.
- Send frame 0x55 with i_rx_ready=0 → o_rx_valid=1, o_rx_data=0x55, o_fifo_level=1, rising exactly 1 cycle after the stop sample. Then i_rx_ready=1 for one cycle → level 0, o_rx_valid=0.
- Drive i_uart_rx low for 3 cycles, then high → o_busy rises, returns to 0, no push, no error pulse.
- Send 0xA5 with stop bit 0 and hold the line low for 40 cycles, then send 0x3C normally → one o_frame_err pulse only, FIFO holds only 0x3C.
- With i_rx_ready=0, send 0x00..0x0F, then 0xFF → o_fifo_level=16, one o_overrun pulse. Draining yields 0x00..0x0F in order; 0xFF is absent.
- FIFO full, with i_rx_ready=1 asserted exactly in the stop-sample cycle of byte 0x77 → no overrun, level stays 16, 0x77 is the last entry on drain.
- Assert i_rst_n=0 during data bit 4 of a frame → all outputs 0 in the same cycle. After release, a new 0xC3 frame is received correctly with level 1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//   i_clk, i_rst_n : system clock, asynchronous active-low reset
//   i_uart_rx      : serial line from host TX (asynchronous, idles high)
//   o_rx_data      : byte at FIFO head (0 when empty)
//   o_rx_valid     : FIFO not empty
//   i_rx_ready     : consumer accepts head byte when valid && ready
//   o_fifo_level   : number of stored bytes
//   o_busy         : receiver not idle
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_overrun      : one-cycle pulse, good byte dropped because FIFO full
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_uart_rx,
  output logic [7:0]                    o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_busy,
  output logic                          o_frame_err,
  output logic                          o_overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic rxs;
  logic full;
  logic pop;
  logic push;

  assign rxs  = sync2_q;
  assign full = (count_q == LVL_FULL);
  assign pop  = o_rx_valid && i_rx_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          idx_d = '0;
          // A high line at mid-start is a glitch, not a frame.
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = ST_IDLE;
            // A pop in the same cycle frees the slot even when full.
            if (!full || pop) push = 1'b1;
            else              overrun_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      sync1_q     <= i_uart_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign o_rx_valid   = (count_q != '0);
  assign o_rx_data    = o_rx_valid ? mem_q[rd_ptr_q] : '0;
  assign o_fifo_level = count_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;

endmodule
